frame_bram_writer: RTL

FRAME_BRAM_WRITER -- requirements
Module: frame_bram_writer

---
 rtl/frame_pkg.sv | 16 +
 rtl/edge_detect.sv | 25 ++
 rtl/frame_bram_writer.sv | 108 ++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared constants and FSM state type for the frame capture path.
// The frame size here is the VGA default; the writer can be resized through its parameters.
package frame_pkg;
  localparam int VGA_WIDTH    = 640;
  localparam int VGA_HEIGHT   = 480;
  localparam int FRAME_PIXELS = 307200;
  localparam int ADDR_W       = 19;
  localparam int PIX_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_WRITE    = 2'd2,
    ST_READY    = 2'd3
  } state_e;
endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: rise is high for the cycle in which sig_in is high
// and its registered copy from the previous cycle is still low.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);
  logic in_q;
  logic in_d;

  always_comb begin
    in_d = sig_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_d;
    end
  end

  assign rise = sig_in && !in_q;
endmodule

// File: rtl/frame_bram_writer.sv
// Captures one raster-order frame from a pixel stream into a BRAM on request and
// holds it until the consumer's done flag rises.
module frame_bram_writer #(
  parameter int IMG_WIDTH  = frame_pkg::VGA_WIDTH,
  parameter int IMG_HEIGHT = frame_pkg::VGA_HEIGHT,
  parameter int PIX_W      = frame_pkg::PIX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          capture_req,
  input  logic                          pix_valid,
  input  logic                          pix_sof,
  input  logic [PIX_W-1:0]              pix_data,
  input  logic                          max_ready,
  output logic                          bram_we,
  output logic [frame_pkg::ADDR_W-1:0]  bram_write_address,
  output logic [PIX_W-1:0]              bram_wdata,
  output logic                          static_bram_rdy,
  output logic                          busy,
  output logic                          frame_error
);
  import frame_pkg::*;

  localparam int                FRAME_SIZE = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_SIZE - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   wr_addr;
  logic [PIX_W-1:0]    wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic                max_rise;

  edge_detect u_max_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (max_ready),
    .rise   (max_rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    // A start-of-frame pixel always restarts the raster at address 0.
    wr_addr = pix_sof ? '0 : cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (capture_req) begin
          state_d = ST_WAIT_SOF;
        end
      end
      ST_WAIT_SOF, ST_WRITE: begin
        if (pix_valid && (pix_sof || (state_q == ST_WRITE))) begin
          we_d    = 1'b1;
          addr_d  = wr_addr;
          wdata_d = pix_data;
          err_d   = pix_sof && (state_q == ST_WRITE) && (cnt_q != '0);
          if (wr_addr == LAST_ADDR) begin
            state_d = ST_READY;
            cnt_d   = '0;
          end else begin
            state_d = ST_WRITE;
            cnt_d   = wr_addr + 1'b1;
          end
        end
      end
      ST_READY: begin
        if (max_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign bram_we            = we_q;
  assign bram_write_address = addr_q;
  assign bram_wdata         = wdata_q;
  assign frame_error        = err_q;
  assign static_bram_rdy    = (state_q == ST_READY);
  assign busy               = (state_q == ST_WAIT_SOF) || (state_q == ST_WRITE);
endmodule
